// File: rtl/shift_ex_stage_if.sv
// Handshake/bus bundle between ID, the hazard unit and the shift execute stage.
interface shift_ex_stage_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 4;
    localparam int unsigned DST_W  = 4;
    localparam int unsigned OP_W   = 2;

    logic              in_valid;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_src;
    logic [AMT_W-1:0]  in_amt;
    logic [DST_W-1:0]  in_dst;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [DST_W-1:0]  out_dst;
    logic              flag_z;

    modport master (
        output in_valid, in_op, in_src, in_amt, in_dst, stall, flush,
        input  out_valid, out_data, out_dst, flag_z
    );

    modport slave (
        input  in_valid, in_op, in_src, in_amt, in_dst, stall, flush,
        output out_valid, out_data, out_dst, flag_z
    );
endinterface

// File: rtl/shift_ex_stage.sv
// Two-stage execute shift unit: ID/EX operand register, combinational shifter,
// EX/MEM result register plus architectural Z flag. Honours stall and flush.
module shift_ex_stage (
    input logic             clk,
    input logic             rst,
    shift_ex_stage_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 4;
    localparam int unsigned DST_W  = 4;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_SLL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRA = 2'b01;
    localparam logic [OP_W-1:0] OP_ROR = 2'b10;
    localparam logic [OP_W-1:0] OP_RSV = 2'b11;

    logic              v1;
    logic [OP_W-1:0]   op1;
    logic [DATA_W-1:0] src1;
    logic [AMT_W-1:0]  amt1;
    logic [DST_W-1:0]  dst1;
    logic [DATA_W-1:0] result_c;
    logic [4:0]        ror_back_c;

    // Shifter; a rotate by 0 shifts the wrapped half out entirely (<< 16).
    always_comb begin
        result_c   = src1;
        ror_back_c = 5'(DATA_W) - 5'(amt1);
        case (op1)
            OP_SLL:  result_c = src1 << amt1;
            OP_SRA:  result_c = $unsigned($signed(src1) >>> amt1);
            OP_ROR:  result_c = (src1 >> amt1) | (src1 << ror_back_c);
            OP_RSV:  result_c = src1;
            default: result_c = src1;
        endcase
    end

    // Stage 2 and flag_z advance whenever not stalled; flush only squashes stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            op1           <= '0;
            src1          <= '0;
            amt1          <= '0;
            dst1          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_dst   <= '0;
            bus.flag_z    <= 1'b0;
        end else begin
            if (!bus.stall) begin
                bus.out_valid <= v1;
                bus.out_data  <= result_c;
                bus.out_dst   <= dst1;
                if (v1 && (op1 != OP_RSV)) begin
                    bus.flag_z <= (result_c == '0);
                end
            end
            if (bus.flush) begin
                v1 <= 1'b0;
            end else if (!bus.stall) begin
                v1   <= bus.in_valid;
                op1  <= bus.in_op;
                src1 <= bus.in_src;
                amt1 <= bus.in_amt;
                dst1 <= bus.in_dst;
            end
        end
    end
endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: directed table, hand-written corner
// sequences and a randomized run against a bit-level reference model.
module tb_shift_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    shift_ex_stage_if bus ();

    shift_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] src;
        logic [3:0]  amt;
        logic [15:0] exp;
    } vec_t;

    // Reference model state: pending ID/EX entry and visible outputs.
    logic        m_v1;
    logic [1:0]  m_op1;
    logic [15:0] m_src1;
    logic [3:0]  m_amt1;
    logic [3:0]  m_dst1;
    logic        m_ov;
    logic [15:0] m_od;
    logic [3:0]  m_odst;
    logic        m_z;
    logic        m_known;

    // Bit i of each result straight from the shift/rotate definitions.
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] src,
                                               input logic [3:0] amt);
        logic [15:0] r;
        int a;
        a = int'(amt);
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                2'd0:    r[i] = (i >= a) ? src[i-a] : 1'b0;
                2'd1:    r[i] = src[(i + a > 15) ? 15 : i + a];
                2'd2:    r[i] = src[(i + a) % 16];
                default: r[i] = src[i];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] src,
                         input logic [3:0] amt, input logic [3:0] dst,
                         input logic st, input logic fl);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_src   = src;
        bus.in_amt   = amt;
        bus.in_dst   = dst;
        bus.stall    = st;
        bus.flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic model_edge();
        logic [15:0] res;
        if (rst) begin
            m_v1 = 1'b0; m_op1 = '0; m_src1 = '0; m_amt1 = '0; m_dst1 = '0;
            m_ov = 1'b0; m_od = '0; m_odst = '0; m_z = 1'b0; m_known = 1'b1;
        end else begin
            if (!bus.stall) begin
                res     = ref_result(m_op1, m_src1, m_amt1);
                m_ov    = m_v1;
                m_od    = res;
                m_odst  = m_dst1;
                m_known = m_v1;
                if (m_v1 && m_op1 != 2'd3) m_z = (res == 16'h0);
            end
            if (bus.flush) begin
                m_v1 = 1'b0;
            end else if (!bus.stall) begin
                m_v1 = bus.in_valid; m_op1 = bus.in_op; m_src1 = bus.in_src;
                m_amt1 = bus.in_amt; m_dst1 = bus.in_dst;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("model_flag_z", 32'(bus.flag_z), 32'(m_z));
        if (m_known) begin
            chk("model_out_data", 32'(bus.out_data), 32'(m_od));
            chk("model_out_dst", 32'(bus.out_dst), 32'(m_odst));
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [15:0] d,
                           input logic [3:0] dst, input logic z);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({name, "_data"}, 32'(bus.out_data), 32'(d));
        chk({name, "_dst"}, 32'(bus.out_dst), 32'(dst));
        chk({name, "_z"}, 32'(bus.flag_z), 32'(z));
    endtask

    vec_t vecs [14];
    logic exp_z;

    initial begin
        vecs[0]  = '{2'd0, 16'h0001, 4'd15, 16'h8000};
        vecs[1]  = '{2'd1, 16'h8000, 4'd15, 16'hFFFF};
        vecs[2]  = '{2'd1, 16'h4000, 4'd15, 16'h0000};
        vecs[3]  = '{2'd2, 16'h0001, 4'd1,  16'h8000};
        vecs[4]  = '{2'd2, 16'h1234, 4'd4,  16'h4123};
        vecs[5]  = '{2'd2, 16'hABCD, 4'd0,  16'hABCD};
        vecs[6]  = '{2'd3, 16'h0000, 4'd5,  16'h0000};
        vecs[7]  = '{2'd0, 16'h00F0, 4'd4,  16'h0F00};
        vecs[8]  = '{2'd1, 16'h8421, 4'd3,  16'hF084};
        vecs[9]  = '{2'd0, 16'hFFFF, 4'd0,  16'hFFFF};
        vecs[10] = '{2'd1, 16'h7FFF, 4'd4,  16'h07FF};
        vecs[11] = '{2'd3, 16'h1234, 4'd7,  16'h1234};
        vecs[12] = '{2'd2, 16'h8001, 4'd15, 16'h0003};
        vecs[13] = '{2'd0, 16'h8000, 4'd1,  16'h0000};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk_out("reset", 1'b0, 16'h0, 4'h0, 1'b0);
        rst = 1'b0;

        // Back-to-back table stream: vector i appears one edge after it is accepted.
        exp_z = 1'b0;
        for (int i = 0; i <= 14; i++) begin
            if (i < 14) drive(1'b1, vecs[i].op, vecs[i].src, vecs[i].amt, 4'(i), 1'b0, 1'b0);
            else idle();
            tick();
            if (i >= 1) begin
                if (vecs[i-1].op != 2'd3) exp_z = (vecs[i-1].exp == 16'h0);
                chk_out($sformatf("table%0d", i - 1), 1'b1, vecs[i-1].exp, 4'(i - 1), exp_z);
            end
        end
        idle();
        tick();
        chk("table_drain_valid", 32'(bus.out_valid), 32'd0);

        // Stall for two cycles after B is accepted.
        drive(1'b1, 2'd0, 16'h0003, 4'd1, 4'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 16'h0003, 4'd2, 4'd2, 1'b0, 1'b0);
        tick();
        chk_out("stall_a", 1'b1, 16'h0006, 4'd1, 1'b0);
        drive(1'b0, 2'd0, 16'h0, 4'd0, 4'd0, 1'b1, 1'b0);
        tick();
        chk_out("stall_hold1", 1'b1, 16'h0006, 4'd1, 1'b0);
        tick();
        chk_out("stall_hold2", 1'b1, 16'h0006, 4'd1, 1'b0);
        drive(1'b1, 2'd0, 16'h0003, 4'd3, 4'd3, 1'b0, 1'b0);
        tick();
        chk_out("stall_b", 1'b1, 16'h000C, 4'd2, 1'b0);
        idle();
        tick();
        chk_out("stall_c", 1'b1, 16'h0018, 4'd3, 1'b0);
        tick();
        chk("stall_drain_valid", 32'(bus.out_valid), 32'd0);

        // Flush with a ROR in stage 1: it still retires, the flushed input never does.
        drive(1'b1, 2'd0, 16'h0000, 4'd0, 4'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 16'h0001, 4'd1, 4'd6, 1'b0, 1'b0);
        tick();
        chk_out("flush_zero_op", 1'b1, 16'h0000, 4'd5, 1'b1);
        drive(1'b1, 2'd0, 16'h0001, 4'd3, 4'd7, 1'b0, 1'b1);
        tick();
        chk_out("flush_ror", 1'b1, 16'h8000, 4'd6, 1'b0);
        idle();
        tick();
        chk("flush_bubble_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_bubble_z", 32'(bus.flag_z), 32'd0);
        tick();
        chk("flush_gone_valid", 32'(bus.out_valid), 32'd0);

        // Flush together with stall: stage 2 holds, then a bubble.
        drive(1'b1, 2'd0, 16'h0001, 4'd0, 4'd8, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 16'h0100, 4'd8, 4'd9, 1'b0, 1'b0);
        tick();
        chk_out("fs_x", 1'b1, 16'h0001, 4'd8, 1'b0);
        drive(1'b1, 2'd0, 16'hFFFF, 4'd1, 4'd10, 1'b1, 1'b1);
        tick();
        chk_out("fs_hold", 1'b1, 16'h0001, 4'd8, 1'b0);
        idle();
        tick();
        chk("fs_bubble_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("fs_gone_valid", 32'(bus.out_valid), 32'd0);

        // Reset with two instructions in flight.
        drive(1'b1, 2'd0, 16'h0000, 4'd0, 4'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 16'h0001, 4'd2, 4'd4, 1'b0, 1'b0);
        tick();
        chk_out("rst_pre", 1'b1, 16'h0000, 4'd3, 1'b1);
        idle();
        rst = 1'b1;
        tick();
        chk_out("rst_mid", 1'b0, 16'h0000, 4'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_after1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("rst_after2_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_after2_z", 32'(bus.flag_z), 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom), 4'($urandom),
                  4'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_ex_stage.md
# shift_ex_stage

Two-stage pipelined execute-side shift unit for the 16-bit datapath. Accepts decoded shift instructions from ID (SLL, SRA, ROR with a 4-bit immediate amount) and registers them in an ID/EX operand register. It then computes the result and registers it, together with destination and Z flag, for EX/MEM. Honours pipeline stall and flush, so the hazard unit can drive it directly.

## Interface
- No parameters. Data width is fixed at 16 and shift amount at 4.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID presents a shift instruction this cycle.
- in_op  in  2  00 = SLL, 01 = SRA, 10 = ROR, 11 = reserved.
- in_src  in  16  source register value.
- in_amt  in  4  shift/rotate amount, 0–15.
- in_dst  in  4  destination register number.
- stall  in  1  hold both stages; no input accepted.
- flush  in  1  squash stage-1 contents and this cycle's input.
- out_valid  out  1  stage-2 result is valid.
- out_data  out  16  registered result.
- out_dst  out  4  registered destination.
- flag_z  out  1  zero flag. Updated only by valid, non-reserved ops.

## Operation
- Stage 1 (ID/EX register) holds v1, op1, src1, amt1, dst1.
- Stage 2 (EX/MEM register) holds out_valid, out_data, out_dst.
- flag_z is a separate architectural register.
- Result function, applied to stage-1 contents:
  - SLL: src1 << amt1, zero fill.
  - SRA: arithmetic right shift, sign bit src1[15] replicated.
  - ROR: rotate right by amt1, so bit i of the result = src1[(i+amt1) mod 16].
  - Reserved (11): result = src1.
- Amount 0 returns src1 unchanged for every op.
- Z flag: when stage 1 advances into stage 2 with v1=1 and op1≠11, flag_z is set to (result==16'h0000). Otherwise flag_z holds.
- Advance rules, each cycle, in priority order:
  - rst: v1=0, out_valid=0, out_data=0, out_dst=0, flag_z=0. All stage-1 fields are cleared to 0.
  - flush=1: v1←0, so the incoming instruction is discarded. Stage 2 loads the current stage-1 entry unless stall=1, in which case stage 2 holds. Flush therefore wins over stall for stage 1 only.
  - stall=1 (no flush): stage 1 and stage 2 hold. flag_z holds.
  - Otherwise:
    - stage 2 ← (v1, result, dst1). flag_z updates per the rule above.
    - stage 1 ← (in_valid, in_op, in_src, in_amt, in_dst).
- A bubble (v1=0) moving into stage 2 sets out_valid=0. out_data and out_dst take the computed values but are don't-care. flag_z is untouched.
- No internal backpressure. Throughput is 1 instruction/cycle when stall=0.

## Timing
- Latency: an instruction accepted at edge N (in_valid=1, stall=0, flush=0) appears with out_valid=1 after edge N+1. This holds only if no stall occurs in between, and each stall cycle adds exactly one cycle.
- flag_z changes in the same cycle out_valid rises for that instruction.
- Back-to-back accepts produce back-to-back outputs, in order, with no duplication or loss across any stall pattern.
- Reset mid-operation: the in-flight entries in both stages are lost, and after the reset edge all outputs read 0.
- The first instruction can be accepted on the edge after rst deasserts.
- The result logic is combinational between the two registers. There are no multi-cycle paths.

## Test plan
- Reset, then SLL src=0x0001 amt=15 → two edges later out_valid=1, out_data=0x8000, flag_z=0.
- SRA src=0x8000 amt=15 → 0xFFFF, Z=0. Next cycle, SRA src=0x4000 amt=15 → 0x0000, Z=1. Outputs arrive on consecutive cycles.
- ROR src=0x0001 amt=1 → 0x8000. ROR src=0x1234 amt=4 → 0x4123. ROR src=0xABCD amt=0 → 0xABCD. Reserved op src=0x0000 → out_valid=1, data=0x0000, flag_z unchanged.
- Stream A, B, C (SLL 0x0003 by 1, 2, 3) with stall high for 2 cycles after B is accepted → outputs 0x0006, 0x000C, 0x0018 in order. out_data and flag_z are held during the stall, with no duplicate or lost output.
- flush asserted while stage 1 holds a ROR and in_valid=1 → the older stage-1 entry still reaches stage 2. The next cycle shows out_valid=0 and flag_z unchanged, and the flushed input never appears. Repeat with stall=1 and flush=1 together: stage 2 holds, then a bubble follows.
- Assert rst while two instructions are in flight → after that edge out_valid=0, out_data=0, out_dst=0, flag_z=0, and no result of either instruction ever appears.
